// File: rtl/ram_pkg.sv
// Shared definitions for the RAM1 SRAM controller: bus widths, FSM states
// and a small helper describing which states own the data bus.
package ram_pkg;

  localparam int RAM_ADDR_W = 18;
  localparam int RAM_DATA_W = 16;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD        = 3'd1,
    ST_WR_SETUP  = 3'd2,
    ST_WR_STROBE = 3'd3,
    ST_WR_HOLD   = 3'd4
  } ram_state_e;

  // True for the write phases, where the controller drives the latched data.
  function automatic logic drives_bus(input ram_state_e st);
    logic drv;
    case (st)
      ST_WR_SETUP:  drv = 1'b1;
      ST_WR_STROBE: drv = 1'b1;
      ST_WR_HOLD:   drv = 1'b1;
      default:      drv = 1'b0;
    endcase
    return drv;
  endfunction

endpackage

// File: rtl/ram1_ctrl.sv
// Asynchronous SRAM controller for the RAM1 bank: one read or write per
// request, strobe length set by WAIT_CYCLES, all SRAM strobes straight from flops.
module ram1_ctrl
  import ram_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic [15:0]           addr_i,
  input  logic [15:0]           wdata_i,
  output logic [15:0]           rdata_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [RAM_ADDR_W-1:0] Ram1Addr,
  inout  wire  [RAM_DATA_W-1:0] Ram1Data,
  output logic                  Ram1EN,
  output logic                  Ram1OE,
  output logic                  Ram1WE
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES - 1);

  ram_state_e            state_r;
  ram_state_e            state_nxt_s;
  logic [WAIT_CNT_W-1:0] cnt_r;
  logic [WAIT_CNT_W-1:0] cnt_nxt_s;
  logic [15:0]           addr_r;
  logic [15:0]           wdata_r;
  logic [15:0]           rdata_r;
  logic                  accept_rd_s;
  logic                  accept_wr_s;
  logic                  capture_s;

  logic                  en_r;
  logic                  oe_r;
  logic                  we_r;
  logic                  drv_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  en_nxt_s;
  logic                  oe_nxt_s;
  logic                  we_nxt_s;
  logic                  drv_nxt_s;
  logic                  busy_nxt_s;
  logic                  done_nxt_s;

  // Next-state, wait-counter and latch-enable decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    accept_rd_s = 1'b0;
    accept_wr_s = 1'b0;
    capture_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mem_read_i && !mem_write_i) begin
          state_nxt_s = ST_RD;
          cnt_nxt_s   = WAIT_LOAD;
          accept_rd_s = 1'b1;
        end else if (mem_write_i && !mem_read_i) begin
          state_nxt_s = ST_WR_SETUP;
          cnt_nxt_s   = {WAIT_CNT_W{1'b0}};
          accept_wr_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = {WAIT_CNT_W{1'b0}};
        end
      end
      ST_RD: begin
        if (cnt_r == {WAIT_CNT_W{1'b0}}) begin
          state_nxt_s = ST_IDLE;
          capture_s   = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ST_WR_SETUP: begin
        state_nxt_s = ST_WR_STROBE;
        cnt_nxt_s   = WAIT_LOAD;
      end
      ST_WR_STROBE: begin
        if (cnt_r == {WAIT_CNT_W{1'b0}}) begin
          state_nxt_s = ST_WR_HOLD;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ST_WR_HOLD: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {WAIT_CNT_W{1'b0}};
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {WAIT_CNT_W{1'b0}};
      end
    endcase
  end

  // Strobes are decoded from the next state so the flops present them in the matching cycle.
  always_comb begin
    en_nxt_s   = (state_nxt_s == ST_IDLE);
    oe_nxt_s   = (state_nxt_s != ST_RD);
    we_nxt_s   = (state_nxt_s != ST_WR_STROBE);
    drv_nxt_s  = drives_bus(state_nxt_s);
    busy_nxt_s = (state_nxt_s != ST_IDLE);
    done_nxt_s = (state_r != ST_IDLE) && (state_nxt_s == ST_IDLE);
  end

  // FSM state and wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {WAIT_CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Request latches and read-data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r  <= 16'h0000;
      wdata_r <= 16'h0000;
      rdata_r <= 16'h0000;
    end else begin
      if (accept_rd_s || accept_wr_s) begin
        addr_r <= addr_i;
      end else begin
        addr_r <= addr_r;
      end
      if (accept_wr_s) begin
        wdata_r <= wdata_i;
      end else begin
        wdata_r <= wdata_r;
      end
      if (capture_s) begin
        rdata_r <= Ram1Data;
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  // Registered SRAM strobes and handshake outputs; reset deselects the SRAM at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_r   <= 1'b1;
      oe_r   <= 1'b1;
      we_r   <= 1'b1;
      drv_r  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      en_r   <= en_nxt_s;
      oe_r   <= oe_nxt_s;
      we_r   <= we_nxt_s;
      drv_r  <= drv_nxt_s;
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
    end
  end

  assign Ram1Data = drv_r ? wdata_r : {RAM_DATA_W{1'bz}};
  assign Ram1Addr = {2'b00, addr_r};
  assign Ram1EN   = en_r;
  assign Ram1OE   = oe_r;
  assign Ram1WE   = we_r;
  assign rdata_o  = rdata_r;
  assign busy_o   = busy_r;
  assign done_o   = done_r;

endmodule

// File: doc/ram1_ctrl.md
RAM1_CTRL -- requirements
Module: ram1_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1: cycles the read/write strobe is held, legal range 1..15.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port mem_read_i, input, 1: read request from the memory stage.
REQ-005 SHALL have port mem_write_i, input, 1: write request from the memory stage.
REQ-006 SHALL have port addr_i, input, 16: word address.
REQ-007 SHALL have port wdata_i, input, 16: write data.
REQ-008 SHALL have port rdata_o, output, 16: last data read; holds its value until the next read completes.
REQ-009 SHALL have port busy_o, output, 1: high whenever the FSM is not in IDLE.
REQ-010 SHALL have port done_o, output, 1: one-cycle pulse marking access completion.
REQ-011 SHALL have port Ram1Addr, output, 18: SRAM address, equal to {2'b00, latched addr}.
REQ-012 SHALL have port Ram1Data, inout, 16: SRAM data bus.
REQ-013 SHALL have ports Ram1EN, Ram1OE and Ram1WE, output, 1 each: SRAM chip enable, output enable and write enable, all active-low.

Function
REQ-014 SHALL implement states IDLE, RD, WR_SETUP, WR_STROBE and WR_HOLD.
REQ-015 SHALL, in IDLE with read=1 and write=0, latch addr_i and enter RD.
REQ-016 SHALL, in IDLE with write=1 and read=0, latch addr_i and wdata_i and enter WR_SETUP.
REQ-017 SHALL, in IDLE with both requests high or both low, stay in IDLE and keep the SRAM deselected.
REQ-018 SHALL ignore requests in any state other than IDLE; the requester holds its request until done_o.
REQ-019 SHALL hold RD for WAIT_CYCLES cycles with EN=0, OE=0, WE=1 and the bus at high-Z.
REQ-020 SHALL capture Ram1Data into rdata_o on the last RD edge and then return to IDLE.
REQ-021 SHALL hold WR_SETUP for 1 cycle with EN=0, OE=1, WE=1 and data driven.
REQ-022 SHALL hold WR_STROBE for WAIT_CYCLES cycles with WE=0.
REQ-023 SHALL hold WR_HOLD for 1 cycle with WE=1 and data still driven, then return to IDLE.
REQ-024 SHALL drive Ram1Data with the latched wdata only in WR_SETUP, WR_STROBE and WR_HOLD, and at high-Z otherwise.
REQ-025 SHALL assert OE and WE together in no cycle.
REQ-026 SHALL drive EN, OE and WE directly from flops, with no combinational glitches.
REQ-027 SHALL raise done_o for exactly the first IDLE cycle after an access.
REQ-028 SHALL give a read a latency of WAIT_CYCLES+1 cycles from accept to done_o.
REQ-029 SHALL give a write a latency of WAIT_CYCLES+3 cycles from accept to done_o.
REQ-030 SHALL accept a new request in the same cycle done_o is high, so back-to-back accesses lose no cycle.
REQ-031 SHALL use a 4-bit wait counter that loads WAIT_CYCLES-1 on state entry, decrements to 0, and never wraps.
REQ-032 SHALL keep Ram1Addr stable, equal to the latched address, for the whole access.

Reset
REQ-033 SHALL, while rst=1, force state=IDLE, Ram1EN=Ram1OE=Ram1WE=1, Ram1Data=Z, rdata_o=0, busy_o=0, done_o=0, counter=0, latched addr/data=0, immediately and without waiting for clk.
REQ-034 SHALL, on reset mid-write, release WE asynchronously and not produce done_o for the aborted access.
REQ-035 SHALL treat the first rising edge after rst falls as IDLE with requests sampled.

Structure
REQ-036 SHALL put the state enum, RAM_ADDR_W=18 and RAM_DATA_W=16 in shared package ram_pkg.
REQ-037 SHALL keep the counter and tri-state inline in a single flat module, with no sub-module.

Verification
REQ-038 SHALL cover a read: WAIT_CYCLES=1, SRAM model holds 0x1234 at 0x0040, read 0x0040 -> OE low for 1 cycle, done_o 2 cycles after accept, rdata_o=0x1234.
REQ-039 SHALL cover a write: write 0xBEEF to 0x0100 -> WE low for 1 cycle, data driven 3 cycles, done_o at cycle 4, model location 0x0100=0xBEEF.
REQ-040 SHALL cover back-to-back: write 0xA5A5 to 0x0002, then read 0x0002 issued in the done_o cycle -> rdata_o=0xA5A5, no idle gap, OE/WE never both low.
REQ-041 SHALL cover conflict and idle: read=write=1 for 5 cycles -> EN=OE=WE=1, busy_o=0, bus Z throughout.
REQ-042 SHALL cover reset mid-access: rst pulsed during WR_STROBE -> WE=1 within the same cycle, no done_o, next read behaves normally.
REQ-043 SHALL cover timing: WAIT_CYCLES=3 read -> OE low exactly 3 cycles, done_o 4 cycles after accept.
